lfsr_prng: RTL and testbench
============================

# lfsr_prng

Parametrised Galois LFSR pseudo-random generator; the successor to the fixed 16-bit LFSR in the simulator datapath. It adds configurable width, polynomial and multi-step advance per transfer. Output is a valid/ready stream, with runtime reseed, zero-seed protection, and a period-wrap indicator. It feeds randomised stimulus and noise sources inside the simulator fabric.

## Interface
- WIDTH, 16, state and output width (≥ 2)
- TAPS, 16'h8005, Galois feedback mask; bit i set ⇒ state bit i XORed with outgoing MSB; bit 0 must be 1
- STEPS, 1, single-bit shifts applied per accepted transfer (1..WIDTH)
- SEED_DEFAULT, 1, reset seed and zero-seed substitute; must be nonzero
- CNT_W, 32, width of step_count_out
- clk_in  input  1  clock, rising edge
- rst_n_in  input  1  reset, asynchronous, active-low
- seed_in  input  WIDTH  seed value
- seed_load_in  input  1  load seed_in this cycle
- ready_in  input  1  consumer ready
- valid_out  output  1  q_out holds a valid word
- q_out  output  WIDTH  current LFSR state
- wrap_out  output  1  one-cycle pulse: the state just returned to the active seed
- step_count_out  output  CNT_W  accepted transfers since last load/wrap

## Operation
- Single step: msb = s[WIDTH-1]; s' = {s[WIDTH-2:0],1'b0} ^ (msb ? TAPS : 0). A transfer applies STEPS chained single steps combinationally.
- Active seed register: holds the last loaded seed (after zero substitution); reset value SEED_DEFAULT.
- FSM states:
  - LOAD: valid_out=0. Moves to RUN on the next clock.
  - RUN: valid_out=1.
- Reset drives LOAD with state = SEED_DEFAULT.
- Transfer occurs when valid_out && ready_in and seed_load_in=0. On a transfer: state ← STEPS-step(state) and step_count_out increments.
- Wrap: if the post-transfer state equals the active seed, wrap_out pulses on the same edge and step_count_out becomes 0.
- Load: seed_load_in=1 in any state loads the state with seed_in (or SEED_DEFAULT if seed_in==0). The active seed is updated to the same value, step_count_out is cleared, and the FSM goes to LOAD.
- Load beats a simultaneous transfer: no advance and no count. The consumer must discard a word whose transfer coincides with a load.
- ready_in low in RUN: state, q_out and count hold.
- The zero state is unreachable: seeds are substituted and TAPS[0]=1.
- step_count_out wraps modulo 2^CNT_W; no saturation.

## Timing
- Reset (async assert) values: q_out = SEED_DEFAULT, valid_out=0, wrap_out=0, step_count_out=0, FSM in LOAD.
- valid_out rises on the first clock edge after rst_n_in deasserts.
- Load latency: q_out shows the new seed the edge after seed_load_in. valid_out stays low that cycle and returns high one edge later.
- Transfer latency: the next word appears on q_out the edge after the handshake. One word per cycle is sustained while ready_in=1.
- wrap_out is registered and high for exactly one cycle, aligned with q_out = active seed.
- Reset asserted mid-operation clears everything immediately, independent of clk_in.

## Structure
- Package lfsr_pkg holds:
  - function galois_step(state, taps), generic on width via parameterised usage;
  - named tap constants: TAPS_CRC16 = 16'h8005, TAPS_4 = 4'h9, TAPS_32 = 32'h0040_0007;
  - FSM state enum {LOAD, RUN}.
- No sub-module: the unrolled step is a loop over the package function.
- Elaboration-time assertions: STEPS in 1..WIDTH, TAPS[0]=1, SEED_DEFAULT≠0.

## Test plan
- Reset behaviour, WIDTH=16, TAPS=16'h8005, STEPS=1: hold reset, release, ready_in=1 → valid_out rises after one edge; q_out sequence 0x0001, 0x0002, 0x0004.
- Feedback and multi-step: load seed 0x8000 with STEPS=1 → next words 0x8005, 0x800F. Same load with STEPS=2 → next word 0x800F.
- Full period, WIDTH=4, TAPS=4'h9, seed 0x1, ready_in=1:
  - all 15 nonzero values appear exactly once;
  - step_count_out reaches 14;
  - the 15th transfer gives q_out=0x1, wrap_out=1 for one cycle, count=0.
- Backpressure: toggle ready_in randomly → q_out and count hold while ready_in=0; the word stream matches the model with no skips or duplicates.
- Load edge cases:
  - seed_in=0 → loads SEED_DEFAULT;
  - seed_load_in asserted together with ready_in → no advance, count=0, valid_out low for one cycle.
- Async reset mid-stream: assert rst_n_in between edges → outputs return to reset values immediately, without waiting for clk_in.

Source files
------------

// File: rtl/lfsr_pkg.sv
// Shared types, tap constants and the single-step Galois LFSR function.
package lfsr_pkg;

  // Widest LFSR the generic step function supports
  localparam int unsigned MAX_W = 64;

  typedef logic [MAX_W-1:0] word_t;

  // Named feedback masks (bit 0 set on all of them)
  localparam logic [15:0] TAPS_CRC16 = 16'h8005;
  localparam logic [3:0]  TAPS_4     = 4'h9;
  localparam logic [31:0] TAPS_32    = 32'h0040_0007;

  typedef enum logic {
    LOAD = 1'b0,
    RUN  = 1'b1
  } state_e;

  // One Galois shift of a width-bit state held in the low bits of a word_t
  function automatic word_t galois_step(input word_t state, input word_t taps,
                                        input int unsigned width);
    word_t mask;
    word_t shifted;
    logic  msb;
    mask    = (width >= MAX_W) ? '1 : ((MAX_W'(1) << width) - MAX_W'(1));
    msb     = |(state & (MAX_W'(1) << (width - 1)));
    shifted = (state << 1) & mask;
    return msb ? (shifted ^ (taps & mask)) : shifted;
  endfunction

endpackage

// File: rtl/lfsr_prng.sv
// Parametrised Galois LFSR PRNG with valid/ready output, reseed and wrap pulse.
module lfsr_prng
  import lfsr_pkg::*;
#(
  parameter int unsigned      WIDTH        = 16,
  parameter logic [WIDTH-1:0] TAPS         = WIDTH'(16'h8005),
  parameter int unsigned      STEPS        = 1,
  parameter logic [WIDTH-1:0] SEED_DEFAULT = WIDTH'(1),
  parameter int unsigned      CNT_W        = 32
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic [WIDTH-1:0] seed_in,
  input  logic             seed_load_in,
  input  logic             ready_in,
  output logic             valid_out,
  output logic [WIDTH-1:0] q_out,
  output logic             wrap_out,
  output logic [CNT_W-1:0] step_count_out
);

  // Parameter sanity, rejected at elaboration
  if (WIDTH < 2 || WIDTH > MAX_W) begin : g_bad_width
    $error("lfsr_prng: WIDTH must be in 2..%0d", MAX_W);
  end
  if (STEPS < 1 || STEPS > WIDTH) begin : g_bad_steps
    $error("lfsr_prng: STEPS must be in 1..WIDTH");
  end
  if (TAPS[0] != 1'b1) begin : g_bad_taps
    $error("lfsr_prng: TAPS bit 0 must be set");
  end
  if (SEED_DEFAULT == '0) begin : g_bad_seed
    $error("lfsr_prng: SEED_DEFAULT must be nonzero");
  end

  state_e             fsm_q,   fsm_d;
  logic [WIDTH-1:0]   lfsr_q,  lfsr_d;
  logic [WIDTH-1:0]   seed_q,  seed_d;
  logic [CNT_W-1:0]   cnt_q,   cnt_d;
  logic               wrap_q,  wrap_d;
  logic               valid_q, valid_d;
  logic [WIDTH-1:0]   adv_c;
  logic [WIDTH-1:0]   seed_sub_c;

  // STEPS chained single shifts of the current state
  always_comb begin
    adv_c = lfsr_q;
    for (int unsigned i = 0; i < STEPS; i++) begin
      adv_c = WIDTH'(galois_step(MAX_W'(adv_c), MAX_W'(TAPS), WIDTH));
    end
  end

  // A zero seed would lock the LFSR, so it is replaced by the default
  assign seed_sub_c = (seed_in == '0) ? SEED_DEFAULT : seed_in;

  // Next-state: load wins over a transfer; wrap compares against the active seed
  always_comb begin
    fsm_d   = fsm_q;
    lfsr_d  = lfsr_q;
    seed_d  = seed_q;
    cnt_d   = cnt_q;
    wrap_d  = 1'b0;
    if (seed_load_in) begin
      lfsr_d = seed_sub_c;
      seed_d = seed_sub_c;
      cnt_d  = '0;
      fsm_d  = LOAD;
    end else begin
      case (fsm_q)
        LOAD: fsm_d = RUN;
        RUN: begin
          if (ready_in) begin
            lfsr_d = adv_c;
            if (adv_c == seed_q) begin
              wrap_d = 1'b1;
              cnt_d  = '0;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
        default: fsm_d = LOAD;
      endcase
    end
    valid_d = (fsm_d == RUN);
  end

  // State and output registers
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      fsm_q   <= LOAD;
      lfsr_q  <= SEED_DEFAULT;
      seed_q  <= SEED_DEFAULT;
      cnt_q   <= '0;
      wrap_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      fsm_q   <= fsm_d;
      lfsr_q  <= lfsr_d;
      seed_q  <= seed_d;
      cnt_q   <= cnt_d;
      wrap_q  <= wrap_d;
      valid_q <= valid_d;
    end
  end

  assign valid_out      = valid_q;
  assign q_out          = lfsr_q;
  assign wrap_out       = wrap_q;
  assign step_count_out = cnt_q;

endmodule

// File: tb/tb_lfsr_prng.sv
// Self-checking bench: three lfsr_prng configurations against a polynomial-arithmetic model.
module tb_lfsr_prng;

  logic        clk;
  logic        rst_n;
  logic [15:0] seed_v [3];
  logic        ld     [3];
  logic        rdy    [3];

  logic [15:0] q_a, q_b;
  logic [3:0]  q_c;
  logic        v_a, v_b, v_c, w_a, w_b, w_c;
  logic [31:0] c_a, c_b, c_c;

  lfsr_prng #(.WIDTH(16), .TAPS(16'h8005), .STEPS(1), .SEED_DEFAULT(16'h0001), .CNT_W(32)) u_a (
    .clk_in(clk), .rst_n_in(rst_n), .seed_in(seed_v[0]), .seed_load_in(ld[0]),
    .ready_in(rdy[0]), .valid_out(v_a), .q_out(q_a), .wrap_out(w_a), .step_count_out(c_a));

  lfsr_prng #(.WIDTH(16), .TAPS(16'h8005), .STEPS(2), .SEED_DEFAULT(16'h0001), .CNT_W(32)) u_b (
    .clk_in(clk), .rst_n_in(rst_n), .seed_in(seed_v[1]), .seed_load_in(ld[1]),
    .ready_in(rdy[1]), .valid_out(v_b), .q_out(q_b), .wrap_out(w_b), .step_count_out(c_b));

  lfsr_prng #(.WIDTH(4), .TAPS(4'h9), .STEPS(1), .SEED_DEFAULT(4'h1), .CNT_W(32)) u_c (
    .clk_in(clk), .rst_n_in(rst_n), .seed_in(seed_v[2][3:0]), .seed_load_in(ld[2]),
    .ready_in(rdy[2]), .valid_out(v_c), .q_out(q_c), .wrap_out(w_c), .step_count_out(c_c));

  always #5 clk = ~clk;

  int n_cmp;
  int n_bad;

  int unsigned wid [3] = '{16, 16, 4};
  logic [15:0] tap [3] = '{16'h8005, 16'h8005, 16'h0009};
  int unsigned stp [3] = '{1, 2, 1};

  logic [15:0] m_q    [3];
  logic [15:0] m_seed [3];
  logic [31:0] m_cnt  [3];
  logic        m_val  [3];
  logic        m_wrap [3];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Multiply the state polynomial by x^k and reduce modulo x^w + taps
  function automatic logic [15:0] ref_next(input logic [15:0] s, input int unsigned w,
                                           input logic [15:0] taps, input int unsigned k);
    logic [63:0] p;
    logic [63:0] poly;
    p    = 64'(s) << k;
    poly = (64'd1 << w) | 64'(taps);
    for (int b = 63; b >= 0; b--) begin
      if (b >= int'(w) && p[b]) p = p ^ (poly << (b - int'(w)));
    end
    return 16'(p);
  endfunction

  function automatic logic [15:0] wmask(input int unsigned w);
    return 16'((32'd1 << w) - 32'd1);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_q[i] = 16'h0001; m_seed[i] = 16'h0001; m_cnt[i] = 0; m_val[i] = 1'b0; m_wrap[i] = 1'b0;
    end
  endtask

  // Behaviour of one clock edge for instance i
  task automatic model_step(input int i);
    logic [15:0] s;
    if (ld[i]) begin
      s = seed_v[i] & wmask(wid[i]);
      if (s == 16'h0) s = 16'h0001;
      m_q[i] = s; m_seed[i] = s; m_cnt[i] = 0; m_val[i] = 1'b0; m_wrap[i] = 1'b0;
    end else begin
      m_wrap[i] = 1'b0;
      if (m_val[i] && rdy[i]) begin
        m_q[i] = ref_next(m_q[i], wid[i], tap[i], stp[i]);
        if (m_q[i] == m_seed[i]) begin
          m_wrap[i] = 1'b1;
          m_cnt[i]  = 0;
        end else begin
          m_cnt[i] = m_cnt[i] + 1;
        end
      end
      m_val[i] = 1'b1;
    end
  endtask

  task automatic check_all(input string ph);
    check({ph, " q[a]"},   32'(q_a), 32'(m_q[0]));
    check({ph, " v[a]"},   32'(v_a), 32'(m_val[0]));
    check({ph, " w[a]"},   32'(w_a), 32'(m_wrap[0]));
    check({ph, " cnt[a]"}, c_a,      m_cnt[0]);
    check({ph, " q[b]"},   32'(q_b), 32'(m_q[1]));
    check({ph, " v[b]"},   32'(v_b), 32'(m_val[1]));
    check({ph, " w[b]"},   32'(w_b), 32'(m_wrap[1]));
    check({ph, " cnt[b]"}, c_b,      m_cnt[1]);
    check({ph, " q[c]"},   32'(q_c), 32'(m_q[2]));
    check({ph, " v[c]"},   32'(v_c), 32'(m_val[2]));
    check({ph, " w[c]"},   32'(w_c), 32'(m_wrap[2]));
    check({ph, " cnt[c]"}, c_c,      m_cnt[2]);
  endtask

  task automatic tick(input string ph);
    for (int i = 0; i < 3; i++) model_step(i);
    @(posedge clk);
    #1;
    check_all(ph);
  endtask

  task automatic set_in(input int i, input logic l, input logic r, input logic [15:0] s);
    ld[i] = l; rdy[i] = r; seed_v[i] = s;
  endtask

  initial begin
    logic [15:0] seen;
    int          dups;
    n_cmp = 0;
    n_bad = 0;
    clk   = 1'b0;
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) set_in(i, 1'b0, 1'b1, 16'h0);
    model_reset();

    // Reset values, then valid one edge after release and the 1,2,4 sequence
    #12;
    check_all("reset");
    rst_n = 1'b1;
    tick("release");
    check("first_word", 32'(q_a), 32'h0001);
    check("first_valid", 32'(v_a), 32'h1);
    tick("run");
    check("second_word", 32'(q_a), 32'h0002);
    tick("run");
    check("third_word", 32'(q_a), 32'h0004);

    // Load 0x8000 while ready is high: no advance, count cleared, valid low one cycle
    set_in(0, 1'b1, 1'b1, 16'h8000);
    set_in(1, 1'b1, 1'b1, 16'h8000);
    set_in(2, 1'b0, 1'b0, 16'h0);
    tick("load");
    check("load_q", 32'(q_a), 32'h8000);
    check("load_valid", 32'(v_a), 32'h0);
    check("load_cnt", c_a, 32'h0);
    ld[0] = 1'b0; ld[1] = 1'b0;
    tick("load_rec");
    check("load_rec_valid", 32'(v_a), 32'h1);
    tick("fb");
    check("fb_step1", 32'(q_a), 32'h8005);
    check("fb_step2x", 32'(q_b), 32'h800F);
    tick("fb");
    check("fb_step1b", 32'(q_a), 32'h800F);

    // Zero seed is replaced by the default
    set_in(0, 1'b1, 1'b0, 16'h0000);
    tick("zseed");
    check("zero_seed", 32'(q_a), 32'h0001);
    ld[0] = 1'b0;
    rdy[0] = 1'b0; rdy[1] = 1'b0;

    // Full period of the 4-bit LFSR
    set_in(2, 1'b1, 1'b1, 16'h0001);
    tick("p_load");
    ld[2] = 1'b0;
    tick("p_rec");
    seen = '0;
    dups = 0;
    for (int t = 0; t < 15; t++) begin
      tick("period");
      if (seen[q_c]) dups++;
      seen[q_c] = 1'b1;
      if (t == 13) check("period_cnt14", c_c, 32'd14);
    end
    check("period_wrap_q", 32'(q_c), 32'h1);
    check("period_wrap", 32'(w_c), 32'h1);
    check("period_wrap_cnt", c_c, 32'h0);
    check("period_dups", 32'(dups), 32'h0);
    check("period_all", 32'(seen), 32'h0000FFFE);
    tick("post_wrap");
    check("wrap_one_cycle", 32'(w_c), 32'h0);

    // Random backpressure and occasional reseeds (including zero seeds)
    for (int n = 0; n < 300; n++) begin
      for (int i = 0; i < 3; i++) begin
        rdy[i]    = 1'($urandom_range(0, 1));
        ld[i]     = ($urandom_range(0, 31) == 0);
        seed_v[i] = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
      end
      tick("rand");
    end

    // Asynchronous reset asserted between edges
    for (int i = 0; i < 3; i++) set_in(i, 1'b0, 1'b1, 16'h0);
    tick("pre_rst");
    tick("pre_rst");
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    #1;
    rst_n = 1'b1;
    tick("post_rst");
    tick("post_rst");
    check("post_rst_q", 32'(q_a), 32'h0002);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
